// File: rtl/apmu_pmc_counter_bank.sv
// Performance-counter bank behind the core's PMC port: event counters with
// overflow thresholds, a period timer, register access and blocking waits.
package apmu_ibex_pkg;
  typedef enum logic [1:0] {
    PMC_IDLE = 2'd0,
    PMC_REQ  = 2'd1,
    PMC_WFP  = 2'd2,
    PMC_WFO  = 2'd3
  } pmc_op_e;
endpackage

module apmu_pmc_counter_bank #(
  parameter int unsigned NUM_COUNTERS = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  apmu_ibex_pkg::pmc_op_e  counter_op_i,
  output logic                    counter_gnt_o,
  output logic                    counter_rvalid_o,
  output logic                    counter_err_o,
  input  logic [31:0]             counter_addr_i,
  input  logic                    counter_we_i,
  input  logic [31:0]             counter_wdata_i,
  output logic [31:0]             counter_rdata_o,
  input  logic [NUM_COUNTERS-1:0] event_i,
  output logic                    ovf_irq_o
);
  import apmu_ibex_pkg::*;

  typedef enum logic [1:0] {IDLE, RESP, WAIT_P, WAIT_O} state_e;

  state_e                  state_q, state_d;
  logic                    rvalid_q, rvalid_d;
  logic                    err_q, err_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    ovf_irq_q;
  logic [NUM_COUNTERS-1:0] mask_q, mask_d;
  logic                    clr_pend_q, clr_pend_d;

  logic                    en_q;
  logic [31:0]             period_q;
  logic [31:0]             timer_q, timer_d;
  logic [31:0]             pcnt_q, pcnt_d;
  logic [NUM_COUNTERS-1:0] ovf_q, ovf_d, ovf_set, ovf_clr;
  logic [31:0]             cnt_q [NUM_COUNTERS];
  logic [31:0]             cnt_d [NUM_COUNTERS];
  logic [31:0]             thr_q [NUM_COUNTERS];

  logic [5:0]              widx;
  logic                    sel_ctrl, sel_period, sel_ovf;
  logic [NUM_COUNTERS-1:0] sel_cnt, sel_thr;
  logic                    dec_err;
  logic [31:0]             rd_val;

  logic                    req_acc, wr_ok;
  logic                    wr_ctrl, wr_period, wr_ovf, clr;
  logic [NUM_COUNTERS-1:0] wr_cnt, wr_thr;
  logic                    tick;

  // Only addr[7:2] selects a register; the remaining address bits are don't-care.
  logic unused_addr;
  assign unused_addr = ^{counter_addr_i[31:8], counter_addr_i[1:0]};

  assign widx = counter_addr_i[7:2];

  always_comb begin
    sel_ctrl   = 1'b0;
    sel_period = 1'b0;
    sel_ovf    = 1'b0;
    sel_cnt    = '0;
    sel_thr    = '0;
    dec_err    = 1'b0;
    rd_val     = '0;
    unique case (widx)
      6'd0: begin
        sel_ctrl  = 1'b1;
        rd_val[0] = en_q;
      end
      6'd1: begin
        sel_period = 1'b1;
        rd_val     = period_q;
      end
      6'd2: begin
        sel_ovf                   = 1'b1;
        rd_val[NUM_COUNTERS-1:0]  = ovf_q;
      end
      6'd3: begin
        rd_val  = pcnt_q;
        dec_err = counter_we_i;
      end
      default: begin
        dec_err = 1'b1;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
          if (widx == 6'(4 + i)) begin
            sel_cnt[i] = 1'b1;
            rd_val     = cnt_q[i];
            dec_err    = 1'b0;
          end
          if (widx == 6'(16 + i)) begin
            sel_thr[i] = 1'b1;
            rd_val     = thr_q[i];
            dec_err    = 1'b0;
          end
        end
      end
    endcase
  end

  assign req_acc   = (state_q == IDLE) && (counter_op_i == PMC_REQ);
  assign wr_ok     = req_acc && counter_we_i && !dec_err;
  assign wr_ctrl   = wr_ok && sel_ctrl;
  assign wr_period = wr_ok && sel_period;
  assign wr_ovf    = wr_ok && sel_ovf;
  assign wr_cnt    = {NUM_COUNTERS{wr_ok}} & sel_cnt;
  assign wr_thr    = {NUM_COUNTERS{wr_ok}} & sel_thr;
  assign clr       = wr_ctrl && counter_wdata_i[1];

  // Counter precedence: CLR, then software write, then event increment.
  always_comb begin
    ovf_set = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr) begin
        cnt_d[i] = '0;
      end else if (wr_cnt[i]) begin
        cnt_d[i] = counter_wdata_i;
      end else if (en_q && event_i[i]) begin
        if (cnt_q[i] == thr_q[i]) begin
          cnt_d[i]   = '0;
          ovf_set[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 32'd1;
        end
      end
    end
  end

  // Hardware set wins over both software W1C and the WFO completion clear.
  always_comb begin
    ovf_clr = '0;
    if (wr_ovf)     ovf_clr = ovf_clr | counter_wdata_i[NUM_COUNTERS-1:0];
    if (clr_pend_q) ovf_clr = ovf_clr | mask_q;
    ovf_d = (ovf_q & ~ovf_clr) | ovf_set;
  end

  assign tick = en_q && (period_q != 32'd0) && (timer_q == period_q - 32'd1) && !clr;

  always_comb begin
    timer_d = timer_q;
    pcnt_d  = pcnt_q;
    if (clr || wr_period) begin
      timer_d = '0;
    end else if (en_q && (period_q != 32'd0)) begin
      timer_d = tick ? 32'd0 : timer_q + 32'd1;
    end
    if (clr) begin
      pcnt_d = '0;
    end else if (tick) begin
      pcnt_d = pcnt_q + 32'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    rvalid_d   = 1'b0;
    err_d      = 1'b0;
    rdata_d    = '0;
    mask_d     = mask_q;
    clr_pend_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (counter_op_i)
          PMC_REQ: begin
            state_d  = RESP;
            rvalid_d = 1'b1;
            err_d    = dec_err;
            rdata_d  = (counter_we_i || dec_err) ? 32'd0 : rd_val;
          end
          PMC_WFP: state_d = WAIT_P;
          PMC_WFO: begin
            if (ovf_q != '0) begin
              state_d                      = RESP;
              rvalid_d                     = 1'b1;
              rdata_d[NUM_COUNTERS-1:0]    = ovf_q;
              mask_d                       = ovf_q;
              clr_pend_d                   = 1'b1;
            end else begin
              state_d = WAIT_O;
            end
          end
          default: state_d = IDLE;
        endcase
      end
      RESP: state_d = IDLE;
      WAIT_P: begin
        if (tick) begin
          state_d  = RESP;
          rvalid_d = 1'b1;
          rdata_d  = pcnt_d;
        end else if (counter_op_i == PMC_IDLE) begin
          state_d = IDLE;
        end
      end
      WAIT_O: begin
        if (ovf_q != '0) begin
          state_d                   = RESP;
          rvalid_d                  = 1'b1;
          rdata_d[NUM_COUNTERS-1:0] = ovf_q;
          mask_d                    = ovf_q;
          clr_pend_d                = 1'b1;
        end else if (counter_op_i == PMC_IDLE) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      ovf_irq_q  <= 1'b0;
      mask_q     <= '0;
      clr_pend_q <= 1'b0;
      en_q       <= 1'b0;
      period_q   <= '0;
      timer_q    <= '0;
      pcnt_q     <= '0;
      ovf_q      <= '0;
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        cnt_q[i] <= '0;
        thr_q[i] <= '1;
      end
    end else begin
      state_q    <= state_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      ovf_irq_q  <= |ovf_d;
      mask_q     <= mask_d;
      clr_pend_q <= clr_pend_d;
      timer_q    <= timer_d;
      pcnt_q     <= pcnt_d;
      ovf_q      <= ovf_d;
      if (wr_ctrl)   en_q     <= counter_wdata_i[0];
      if (wr_period) period_q <= counter_wdata_i;
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (wr_thr[i]) thr_q[i] <= counter_wdata_i;
      end
    end
  end

  assign counter_gnt_o    = (state_q == IDLE);
  assign counter_rvalid_o = rvalid_q;
  assign counter_err_o    = err_q;
  assign counter_rdata_o  = rdata_q;
  assign ovf_irq_o        = ovf_irq_q;

endmodule

// File: tb/tb_apmu_pmc_counter_bank.sv
// Bench for apmu_pmc_counter_bank: register vector table plus hand-built
// wait/overflow sequences, responses checked through an expected-response queue.
module tb_apmu_pmc_counter_bank;
  import apmu_ibex_pkg::*;

  localparam int NC = 4;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  pmc_op_e        counter_op_i = PMC_IDLE;
  logic           counter_gnt_o;
  logic           counter_rvalid_o;
  logic           counter_err_o;
  logic [31:0]    counter_addr_i = '0;
  logic           counter_we_i = 1'b0;
  logic [31:0]    counter_wdata_i = '0;
  logic [31:0]    counter_rdata_o;
  logic [NC-1:0]  event_i = '0;
  logic           ovf_irq_o;

  apmu_pmc_counter_bank #(.NUM_COUNTERS(NC)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .counter_op_i     (counter_op_i),
    .counter_gnt_o    (counter_gnt_o),
    .counter_rvalid_o (counter_rvalid_o),
    .counter_err_o    (counter_err_o),
    .counter_addr_i   (counter_addr_i),
    .counter_we_i     (counter_we_i),
    .counter_wdata_i  (counter_wdata_i),
    .counter_rdata_o  (counter_rdata_o),
    .event_i          (event_i),
    .ovf_irq_o        (ovf_irq_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor: every rvalid must match the oldest queued expectation.
  always @(negedge clk_i) begin
    if (rst_ni && counter_rvalid_o) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rvalid: got rvalid=1 rdata=%0h at cycle %0d, expected none",
                 counter_rdata_o, cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk({mon_e.tag, "_cycle"}, 32'(cyc), 32'(mon_e.cyc));
        chk({mon_e.tag, "_rdata"}, counter_rdata_o, mon_e.rdata);
        chk({mon_e.tag, "_err"}, {31'd0, counter_err_o}, {31'd0, mon_e.err});
      end
    end
  end

  // Called at #1 after a rising edge with the bank idle; returns the same way.
  task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [NC-1:0] ev,
                        input logic [31:0] exp_rdata, input logic exp_err);
    counter_op_i    = PMC_REQ;
    counter_we_i    = we;
    counter_addr_i  = addr;
    counter_wdata_i = wdata;
    event_i         = ev;
    sbq.push_back('{tag: tag, rdata: exp_rdata, err: exp_err, cyc: cyc + 1});
    @(posedge clk_i); #1;
    counter_op_i = PMC_IDLE;
    counter_we_i = 1'b0;
    event_i      = '0;
    @(posedge clk_i); #1;
  endtask

  task automatic start_wait(input string tag, input pmc_op_e op, input int lat,
                            input logic [31:0] exp_rdata);
    counter_op_i = op;
    if (lat > 0) sbq.push_back('{tag: tag, rdata: exp_rdata, err: 1'b0, cyc: cyc + lat});
  endtask

  task automatic wait_resp(input string tag, input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk_i);
      seen = counter_rvalid_o;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s_timeout: got no rvalid within %0d cycles, expected a response", tag, budget);
    end
    counter_op_i = PMC_IDLE;
    @(posedge clk_i); #1;
  endtask

  task automatic tick_cycles(input int n);
    repeat (n) begin
      @(posedge clk_i); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000 time units, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 32'h00, 32'h0,  32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h40, 32'h0,  32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{1'b0, 32'h1C, 32'h0,  32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h0C, 32'h0,  32'h0,        1'b0};
    vecs[4]  = '{1'b1, 32'h40, 32'h3,  32'h0,        1'b0};
    vecs[5]  = '{1'b0, 32'h40, 32'h0,  32'h3,        1'b0};
    vecs[6]  = '{1'b1, 32'h18, 32'h1234, 32'h0,      1'b0};
    vecs[7]  = '{1'b0, 32'h18, 32'h0,  32'h1234,     1'b0};
    vecs[8]  = '{1'b0, 32'h3C, 32'h0,  32'h0,        1'b1};
    vecs[9]  = '{1'b0, 32'h50, 32'h0,  32'h0,        1'b1};
    vecs[10] = '{1'b1, 32'h0C, 32'h55, 32'h0,        1'b1};
    vecs[11] = '{1'b0, 32'h0C, 32'h0,  32'h0,        1'b0};
    vecs[12] = '{1'b1, 32'h04, 32'hAB, 32'h0,        1'b0};
    vecs[13] = '{1'b0, 32'h04, 32'h0,  32'hAB,       1'b0};
    vecs[14] = '{1'b1, 32'h30, 32'hFF, 32'h0,        1'b1};
    vecs[15] = '{1'b0, 32'h20, 32'h0,  32'h0,        1'b1};
    vecs[16] = '{1'b1, 32'h4C, 32'h77, 32'h0,        1'b0};
    vecs[17] = '{1'b0, 32'h4C, 32'h0,  32'h77,       1'b0};
    vecs[18] = '{1'b0, 32'h80, 32'h0,  32'h0,        1'b1};
    vecs[19] = '{1'b1, 32'h04, 32'h0,  32'h0,        1'b0};

    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    chk("rst_gnt",    {31'd0, counter_gnt_o},    32'd1);
    chk("rst_rvalid", {31'd0, counter_rvalid_o}, 32'd0);
    chk("rst_err",    {31'd0, counter_err_o},    32'd0);
    chk("rst_rdata",  counter_rdata_o,           32'd0);
    chk("rst_irq",    {31'd0, ovf_irq_o},        32'd0);

    for (int i = 0; i < 20; i++) begin
      do_req($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata, '0,
             vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // THR0=3, enable, four events: wrap to zero and raise OVF[0].
    do_req("ctrl_en", 1'b1, 32'h00, 32'h1, '0, 32'h0, 1'b0);
    event_i = 4'b0001;
    tick_cycles(4);
    event_i = '0;
    tick_cycles(1);
    chk("ovf0_irq", {31'd0, ovf_irq_o}, 32'd1);
    do_req("cnt0_wrapped", 1'b0, 32'h10, 32'h0, '0, 32'h0, 1'b0);
    do_req("ovf_rd1",      1'b0, 32'h08, 32'h0, '0, 32'h1, 1'b0);
    do_req("ovf_w1c",      1'b1, 32'h08, 32'h1, '0, 32'h0, 1'b0);
    do_req("ovf_rd0",      1'b0, 32'h08, 32'h0, '0, 32'h0, 1'b0);
    chk("irq_cleared", {31'd0, ovf_irq_o}, 32'd0);

    // OVF already set when WFO is accepted.
    do_req("thr1_zero", 1'b1, 32'h44, 32'h0, '0, 32'h0, 1'b0);
    event_i = 4'b0010;
    tick_cycles(1);
    event_i = '0;
    tick_cycles(1);
    start_wait("wfo_now", PMC_WFO, 1, 32'h2);
    wait_resp("wfo_now", 5);
    do_req("ovf_after_wfo", 1'b0, 32'h08, 32'h0, '0, 32'h0, 1'b0);

    // Overflow arrives while WFO waits: event at +2, latch at +3, rvalid at +4.
    start_wait("wfo_late", PMC_WFO, 4, 32'h2);
    tick_cycles(2);
    event_i = 4'b0010;
    tick_cycles(1);
    event_i = '0;
    wait_resp("wfo_late", 10);
    do_req("ovf_after_wfo2", 1'b0, 32'h08, 32'h0, '0, 32'h0, 1'b0);

    // Cancelled WFO: no response, bank idle again, next read normal.
    do_req("cnt1_wr", 1'b1, 32'h14, 32'h5, '0, 32'h0, 1'b0);
    start_wait("wfo_cancel", PMC_WFO, 0, 32'h0);
    tick_cycles(3);
    chk("wfo_busy_gnt", {31'd0, counter_gnt_o}, 32'd0);
    counter_op_i = PMC_IDLE;
    tick_cycles(1);
    chk("wfo_cancel_gnt", {31'd0, counter_gnt_o}, 32'd1);
    do_req("cnt1_rd", 1'b0, 32'h14, 32'h0, '0, 32'h5, 1'b0);

    // Period timer: clear, PERIOD=10, WFP issued with timer=2.
    do_req("ctrl_clr", 1'b1, 32'h00, 32'h3, '0, 32'h0, 1'b0);
    do_req("period10", 1'b1, 32'h04, 32'd10, '0, 32'h0, 1'b0);
    tick_cycles(1);
    start_wait("wfp1", PMC_WFP, 8, 32'd1);
    wait_resp("wfp1", 20);
    tick_cycles(8);
    start_wait("wfp_on_tick", PMC_WFP, 11, 32'd3);
    wait_resp("wfp_on_tick", 20);
    do_req("period0", 1'b1, 32'h04, 32'h0, '0, 32'h0, 1'b0);
    do_req("pcnt_rd", 1'b0, 32'h0C, 32'h0, '0, 32'd3, 1'b0);
    start_wait("wfp_nop", PMC_WFP, 0, 32'h0);
    tick_cycles(5);
    counter_op_i = PMC_IDLE;
    tick_cycles(1);
    chk("wfp_cancel_gnt", {31'd0, counter_gnt_o}, 32'd1);

    // Same-cycle collisions.
    do_req("cnt0_wr_ev", 1'b1, 32'h10, 32'd100, 4'b0001, 32'h0, 1'b0);
    do_req("cnt0_rd100", 1'b0, 32'h10, 32'h0, '0, 32'd100, 1'b0);
    do_req("w1c_vs_set", 1'b1, 32'h08, 32'h2, 4'b0010, 32'h0, 1'b0);
    do_req("ovf_rd_set", 1'b0, 32'h08, 32'h0, '0, 32'h2, 1'b0);
    chk("set_irq", {31'd0, ovf_irq_o}, 32'd1);

    // Reset while a WFP is pending.
    do_req("ovf_clr_all", 1'b1, 32'h08, 32'hF, '0, 32'h0, 1'b0);
    start_wait("wfp_rst", PMC_WFP, 0, 32'h0);
    tick_cycles(2);
    #2 rst_ni = 1'b0;
    counter_op_i = PMC_IDLE;
    #1;
    chk("midrst_gnt",    {31'd0, counter_gnt_o},    32'd1);
    chk("midrst_rvalid", {31'd0, counter_rvalid_o}, 32'd0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    tick_cycles(1);
    do_req("thr0_after_rst",  1'b0, 32'h40, 32'h0, '0, 32'hFFFFFFFF, 1'b0);
    do_req("ctrl_after_rst",  1'b0, 32'h00, 32'h0, '0, 32'h0, 1'b0);
    do_req("cnt0_after_rst",  1'b0, 32'h10, 32'h0, '0, 32'h0, 1'b0);

    tick_cycles(3);
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
